// File: rtl/present80_enc_core.sv
// Iterative PRESENT-80 encryption core: one full round (addRoundKey, sBoxLayer,
// pLayer) plus one key-schedule step per clock, final whitening with K32.
module present80_enc_core #(
  parameter int NUM_ROUNDS = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] plaintext,
  input  logic [79:0] key,
  output logic        busy,
  output logic        done,
  output logic [63:0] ciphertext
);

  localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_e;

  fsm_e        fsm_q,   fsm_d;
  logic [63:0] state_q, state_d;
  logic [79:0] key_q,   key_d;
  logic [4:0]  round_q, round_d;
  logic [63:0] ct_q,    ct_d;
  logic        done_q,  done_d;

  logic [63:0] add_key;
  logic [63:0] sub_out;
  logic [63:0] perm_out;
  logic [79:0] key_rot;
  logic [79:0] key_next;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Bit j moves to (16*j) mod 63; bit 63 stays put. Pure wiring after synthesis.
  function automatic logic [63:0] p_layer(input logic [63:0] s);
    logic [63:0] p;
    p = '0;
    for (int j = 0; j < 64; j++) begin
      p[(j == 63) ? 63 : ((16 * j) % 63)] = s[j];
    end
    return p;
  endfunction

  always_comb begin
    add_key = state_q ^ key_q[79:16];
    sub_out = '0;
    for (int i = 0; i < 16; i++) begin
      sub_out[4*i +: 4] = sbox(add_key[4*i +: 4]);
    end
    perm_out = p_layer(sub_out);
  end

  // Key schedule step: rotate left 61, S-box the top nibble, mix in the round counter.
  assign key_rot  = {key_q[18:0], key_q[79:19]};
  assign key_next = {sbox(key_rot[79:76]), key_rot[75:20],
                     key_rot[19:15] ^ round_q, key_rot[14:0]};

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    ct_d    = ct_q;
    done_d  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          state_d = plaintext;
          key_d   = key;
          round_d = 5'd1;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        state_d = perm_out;
        key_d   = key_next;
        if (round_q == LAST_ROUND) begin
          ct_d   = perm_out ^ key_next[79:16];
          done_d = 1'b1;
          fsm_d  = IDLE;
        end else begin
          round_d = round_q + 5'd1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; every register,
  // including the wide datapath ones, is cleared so an abort leaves nothing stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      round_q <= '0;
      ct_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      ct_q    <= ct_d;
      done_q  <= done_d;
    end
  end

  assign busy       = (fsm_q == RUN);
  assign done       = done_q;
  assign ciphertext = ct_q;

endmodule
